// File: rtl/ej32_pkg.sv
// Shared types and constants for the EJ32 three-requester memory arbiter.
package ej32_pkg;

    localparam int NREQ   = 3;
    localparam int REQ_BR = 0;
    localparam int REQ_LS = 1;
    localparam int REQ_IO = 2;

    typedef enum logic {
        IDLE,
        OWNED
    } arb_state_t;

    typedef logic [1:0] req_idx_t;

    // Requester index successor, wrapping 2 -> 0.
    function automatic req_idx_t next_idx(input req_idx_t i);
        return (i == req_idx_t'(NREQ - 1)) ? '0 : i + req_idx_t'(1);
    endfunction

endpackage

// File: rtl/ej32_mem_arb_if.sv
// Requester and memory-side bus of the EJ32 arbiter; slave = arbiter, master = requesters + memory.
interface ej32_mem_arb_if
    import ej32_pkg::*;
#(
    parameter int ASZ = 17
);

    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     lock;
    logic [NREQ-1:0]     we;
    logic [NREQ*ASZ-1:0] addr_i;
    logic [NREQ*8-1:0]   wdata_i;
    logic [NREQ-1:0]     gnt;
    logic [ASZ-1:0]      mem_addr;
    logic                mem_we;
    logic [7:0]          mem_wdata;
    logic [7:0]          mem_rdata;
    logic [NREQ-1:0]     rvalid;
    logic [7:0]          rdata;

    modport slave (
        input  req, lock, we, addr_i, wdata_i, mem_rdata,
        output gnt, mem_addr, mem_we, mem_wdata, rvalid, rdata
    );

    modport master (
        output req, lock, we, addr_i, wdata_i, mem_rdata,
        input  gnt, mem_addr, mem_we, mem_wdata, rvalid, rdata
    );

endinterface

// File: rtl/ej32_arb_pick.sv
// Combinational winner select: first requester at or after ptr (mod 3), skipping masked
// requesters unless nobody else is asking.
module ej32_arb_pick
    import ej32_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  req_idx_t        ptr,
    output logic            valid,
    output req_idx_t        winner
);

    logic [NREQ-1:0] eff;
    req_idx_t        idx;

    // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
    always_comb begin
        eff    = ((req & ~mask) != '0) ? (req & ~mask) : req;
        valid  = 1'b0;
        winner = ptr;
        idx    = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!valid && eff[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
            idx = next_idx(idx);
        end
    end

endmodule

// File: rtl/ej32_mem_arb.sv
// EJ32 memory arbiter: BR/LS/IO share one single-port byte memory, with locked bursts capped at LOCK_MAX.
// Define EJ32_ARB_RR_EN for round-robin idle arbitration; default is fixed priority BR > LS > IO.
module ej32_mem_arb
    import ej32_pkg::*;
#(
    parameter int ASZ      = 17,
    parameter int LOCK_MAX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    ej32_mem_arb_if.slave  bus
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_t      state, state_nxt;
    req_idx_t        owner, owner_nxt;
    logic [CW-1:0]   beat_cnt, beat_nxt, beat_inc;
    logic [NREQ-1:0] gnt_raw, gnt, rvalid_q;
    logic [NREQ-1:0] mask;
    req_idx_t        ptr;
    logic            pick_valid;
    req_idx_t        pick_idx;

`ifdef EJ32_ARB_RR_EN
    req_idx_t rr_ptr;
    assign ptr  = rr_ptr;
    assign mask = '0;
`else
    logic [NREQ-1:0] mask_q;
    logic            forced;
    assign ptr  = '0;
    assign mask = mask_q;
    // Burst cut off by the beat cap while the owner still wants the bus.
    assign forced = (state == OWNED) && bus.req[owner] && bus.lock[owner]
                    && (beat_inc >= CW'(LOCK_MAX));
`endif

    ej32_arb_pick u_pick (
        .req    (bus.req),
        .mask   (mask),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    assign beat_inc = beat_cnt + CW'(1);

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        beat_nxt  = beat_cnt;
        gnt_raw   = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt_raw[pick_idx] = 1'b1;
                    if (bus.lock[pick_idx]) begin
                        state_nxt = OWNED;
                        owner_nxt = pick_idx;
                        beat_nxt  = CW'(1);
                    end
                end
            end
            OWNED: begin
                if (!bus.req[owner]) begin
                    state_nxt = IDLE;
                    beat_nxt  = '0;
                end else begin
                    gnt_raw[owner] = 1'b1;
                    beat_nxt       = beat_inc;
                    if (!bus.lock[owner] || beat_inc >= CW'(LOCK_MAX)) begin
                        state_nxt = IDLE;
                        beat_nxt  = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant is forced off while reset is held, which also silences mem_we.
    assign gnt = rst_n ? gnt_raw : '0;

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                bus.mem_addr  = bus.addr_i[i*ASZ +: ASZ];
                bus.mem_we    = bus.we[i];
                bus.mem_wdata = bus.wdata_i[i*8 +: 8];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            beat_cnt <= '0;
            rvalid_q <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            beat_cnt <= beat_nxt;
            rvalid_q <= gnt & ~bus.we;
        end
    end

`ifdef EJ32_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (state == IDLE && pick_valid) begin
            rr_ptr <= next_idx(pick_idx);
        end else if (state == OWNED && state_nxt == IDLE) begin
            rr_ptr <= next_idx(owner);
        end
    end
`else
    // The mask lives for exactly one idle arbitration after a capped burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (forced) begin
            mask_q <= NREQ'(1) << owner;
        end else if (state == IDLE) begin
            mask_q <= '0;
        end
    end
`endif

    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Self-checking bench for ej32_mem_arb: directed beats with a read-data scoreboard.
module tb_ej32_mem_arb;
    import ej32_pkg::*;

    localparam int ASZ = 17;

    typedef struct packed {
        logic [2:0] rv;
        logic [7:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    localparam logic [ASZ-1:0] A_BR = 17'h00010;
    localparam logic [ASZ-1:0] A_LS = 17'h00200;
    localparam logic [ASZ-1:0] A_IO = 17'h1FFFF;
    localparam logic [7:0]     D_BR = 8'h11;
    localparam logic [7:0]     D_LS = 8'h22;
    localparam logic [7:0]     D_IO = 8'hA5;

    ej32_mem_arb_if #(.ASZ(ASZ)) bus ();

    ej32_mem_arb #(.ASZ(ASZ), .LOCK_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_val(input logic [ASZ-1:0] a);
        return a[7:0] ^ a[15:8] ^ {7'h2D, a[16]};
    endfunction

    always @(posedge clk) bus.mem_rdata <= mem_val(bus.mem_addr);

    function automatic logic [ASZ-1:0] exp_addr(input logic [2:0] g);
        if (g[0]) return A_BR;
        if (g[1]) return A_LS;
        if (g[2]) return A_IO;
        return '0;
    endfunction

    function automatic logic [7:0] exp_wdata(input logic [2:0] g);
        if (g[0]) return D_BR;
        if (g[1]) return D_LS;
        if (g[2]) return D_IO;
        return '0;
    endfunction

    // One bus cycle: drive after the edge, check at the falling edge, queue the expected read return.
    task automatic beat(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w,
                        input logic [2:0] exp_g, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        bus.req  = r;
        bus.lock = l;
        bus.we   = w;
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, rvalid=%b", name, bus.rvalid);
        end else begin
            e = sb.pop_front();
            if (bus.rvalid !== e.rv) begin
                errors++;
                $display("FAIL %s rvalid: got %b expected %b", name, bus.rvalid, e.rv);
            end
            if (e.rv != 3'b000) begin
                checks++;
                if (bus.rdata !== e.rd) begin
                    errors++;
                    $display("FAIL %s rdata: got %h expected %h", name, bus.rdata, e.rd);
                end
            end
        end
        checks++;
        if (bus.gnt !== exp_g) begin
            errors++;
            $display("FAIL %s gnt: got %b expected %b", name, bus.gnt, exp_g);
        end
        checks++;
        if (bus.mem_addr !== exp_addr(exp_g)) begin
            errors++;
            $display("FAIL %s mem_addr: got %h expected %h", name, bus.mem_addr, exp_addr(exp_g));
        end
        checks++;
        if (bus.mem_we !== |(exp_g & w)) begin
            errors++;
            $display("FAIL %s mem_we: got %b expected %b", name, bus.mem_we, |(exp_g & w));
        end
        checks++;
        if (bus.mem_wdata !== exp_wdata(exp_g)) begin
            errors++;
            $display("FAIL %s mem_wdata: got %h expected %h", name, bus.mem_wdata, exp_wdata(exp_g));
        end
        e.rv = exp_g & ~w;
        e.rd = mem_val(exp_addr(exp_g));
        sb.push_back(e);
    endtask

    task automatic test_reset(input string name);
        exp_t e;
        rst_n    = 1'b0;
        bus.req  = 3'b111;
        bus.we   = 3'b111;
        bus.lock = 3'b000;
        #2;
        checks++;
        if (bus.gnt !== 3'b000 || bus.mem_we !== 1'b0 || bus.rvalid !== 3'b000) begin
            errors++;
            $display("FAIL %s in-reset: gnt=%b mem_we=%b rvalid=%b expected 000/0/000",
                     name, bus.gnt, bus.mem_we, bus.rvalid);
        end
        bus.req = 3'b000;
        bus.we  = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        e = '0;
        sb.push_back(e);
    endtask

    task automatic test_fixed_priority();
        test_reset("fixed_rst");
        beat(3'b011, 3'b000, 3'b000, 3'b001, "fixed_br_ls");
        beat(3'b110, 3'b000, 3'b000, 3'b010, "fixed_ls_io");
        beat(3'b100, 3'b000, 3'b000, 3'b100, "fixed_io");
        beat(3'b000, 3'b000, 3'b000, 3'b000, "fixed_drain");
    endtask

    task automatic test_io_write();
        test_reset("wr_rst");
        beat(3'b100, 3'b000, 3'b100, 3'b100, "io_write");
        beat(3'b000, 3'b000, 3'b000, 3'b000, "io_write_no_rvalid");
    endtask

    task automatic test_lock_cap();
        logic [2:0] exp_seq [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b010};
        test_reset("lock_rst");
        for (int k = 0; k < 6; k++)
            beat(3'b110, 3'b010, 3'b000, exp_seq[k], $sformatf("lock_cap_%0d", k));
        beat(3'b000, 3'b000, 3'b000, 3'b000, "lock_drain");
    endtask

    task automatic test_owned_exit();
        test_reset("exit_rst");
        beat(3'b010, 3'b010, 3'b000, 3'b010, "own_start");
        beat(3'b001, 3'b010, 3'b000, 3'b000, "own_req_drop");
        beat(3'b001, 3'b000, 3'b000, 3'b001, "after_drop");
        beat(3'b010, 3'b010, 3'b000, 3'b010, "own_start2");
        beat(3'b011, 3'b000, 3'b000, 3'b010, "own_unlock_beat");
        beat(3'b011, 3'b000, 3'b000, 3'b001, "after_unlock");
        beat(3'b000, 3'b000, 3'b000, 3'b000, "exit_drain");
    endtask

    task automatic test_back_to_back();
`ifdef EJ32_ARB_RR_EN
        logic [2:0] exp_seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
        logic [2:0] exp_seq [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
        test_reset("b2b_rst");
        for (int k = 0; k < 6; k++)
            beat(3'b111, 3'b000, 3'b000, exp_seq[k], $sformatf("b2b_%0d", k));
        beat(3'b000, 3'b000, 3'b000, 3'b000, "b2b_drain");
    endtask

    task automatic test_reset_mid_burst();
        exp_t e;
        test_reset("mid_rst");
        beat(3'b010, 3'b010, 3'b000, 3'b010, "burst_beat1");
        @(posedge clk);
        #1;
        bus.we = 3'b010;
        #2;
        checks++;
        if (bus.gnt !== 3'b010 || bus.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL burst_beat2: gnt=%b mem_we=%b expected 010/1", bus.gnt, bus.mem_we);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.gnt !== 3'b000 || bus.mem_we !== 1'b0 || bus.rvalid !== 3'b000) begin
            errors++;
            $display("FAIL burst_abort: gnt=%b mem_we=%b rvalid=%b expected 000/0/000",
                     bus.gnt, bus.mem_we, bus.rvalid);
        end
        @(negedge clk);
        bus.req  = 3'b000;
        bus.lock = 3'b000;
        bus.we   = 3'b000;
        rst_n    = 1'b1;
        sb.delete();
        e = '0;
        sb.push_back(e);
        beat(3'b000, 3'b000, 3'b000, 3'b000, "post_rst_quiet");
        beat(3'b001, 3'b000, 3'b000, 3'b001, "post_rst_idle_arb");
        beat(3'b000, 3'b000, 3'b000, 3'b000, "post_rst_drain");
    endtask

    initial begin
        bus.req     = '0;
        bus.lock    = '0;
        bus.we      = '0;
        bus.addr_i  = {A_IO, A_LS, A_BR};
        bus.wdata_i = {D_IO, D_LS, D_BR};
        test_fixed_priority();
        test_io_write();
        test_lock_cap();
        test_owned_exit();
        test_back_to_back();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
